// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: shadow E/M/W destination tracking, RAW stall,
// operand forwarding select and branch flush. HAZ_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] D_rs1,
  input  logic [REG_AW-1:0] D_rs2,
  input  logic              D_rs1_used,
  input  logic              D_rs2_used,
  input  logic [REG_AW-1:0] D_rd,
  input  logic              D_reg_write,
  input  logic              D_is_load,
  input  logic              jb,
  output logic              stall,
  output logic              pc_hold,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              is_load;
  } slot_t;

  slot_t e_s, m_s, w_s;

  logic rs1_e, rs1_m, rs1_w;
  logic rs2_e, rs2_m, rs2_w;
  logic raw;

  // Register 0 is hardwired zero, so it never creates a dependency.
  function automatic logic hit(slot_t s, logic [REG_AW-1:0] r, logic used);
    return used && s.valid && s.wr && (s.rd == r) && (r != '0) && (int'(r) < NUM_REGS);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_s <= '0;
      m_s <= '0;
      w_s <= '0;
    end else begin
      m_s <= e_s;
      w_s <= m_s;
      if (stall || jb) e_s <= '0;
      else             e_s <= {1'b1, D_rd, D_reg_write, D_is_load};
    end
  end

  always_comb begin
    rs1_e = hit(e_s, D_rs1, D_rs1_used);
    rs1_m = hit(m_s, D_rs1, D_rs1_used);
    rs1_w = hit(w_s, D_rs1, D_rs1_used);
    rs2_e = hit(e_s, D_rs2, D_rs2_used);
    rs2_m = hit(m_s, D_rs2, D_rs2_used);
    rs2_w = hit(w_s, D_rs2, D_rs2_used);
    // E results are not yet available to decode; a load in M still lacks its data.
    raw   = rs1_e | rs2_e | ((rs1_m | rs2_m) & m_s.is_load);
  end

  // A taken branch wins over the stall so the PC can load the target.
  assign stall   = raw & ~jb;
  assign pc_hold = stall;
  assign flush_d = jb;
  assign flush_e = jb;

  always_comb begin
    fwd_rs1_sel = 2'd0;
    fwd_rs2_sel = 2'd0;
    if (rs1_m && !m_s.is_load) fwd_rs1_sel = 2'd1;
    else if (rs1_w)            fwd_rs1_sel = 2'd2;
    if (rs2_m && !m_s.is_load) fwd_rs2_sel = 2'd1;
    else if (rs2_w)            fwd_rs2_sel = 2'd2;
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (jb && (flush_cnt != 32'hFFFF_FFFF))    flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer of the `stall` / `jb` control pair consumed by the decode-to-execute pipeline register; it also drives the hold and flush of the fetch/decode side.
- Keeps its own shadow pipeline (E/M/W) of destination-register info, so decisions depend on registered history, not only on current decode fields.
- Detects RAW hazards against in-flight instructions, selects decode-stage operand forwarding, and turns a taken branch/jump into flush signals.

Parameters:
- REG_AW, 5, register index width
- NUM_REGS, 32, register count; index 0 is hardwired zero

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- D_rs1  input  REG_AW  decode rs1 index
- D_rs2  input  REG_AW  decode rs2 index
- D_rs1_used  input  1  instruction reads rs1
- D_rs2_used  input  1  instruction reads rs2
- D_rd  input  REG_AW  decode destination index
- D_reg_write  input  1  instruction writes rd
- D_is_load  input  1  instruction is a load
- jb  input  1  taken branch/jump resolved in E this cycle
- stall  output  1  to Reg_E (insert bubble) and PC/Reg_D (hold)
- pc_hold  output  1  freeze PC
- flush_d  output  1  clear Reg_D
- flush_e  output  1  clear Reg_E (the jb input of Reg_E)
- fwd_rs1_sel  output  2  0 = regfile, 1 = M ALU result, 2 = W writeback data
- fwd_rs2_sel  output  2  same encoding for rs2

Behaviour:
- Shadow slots E, M, W each hold: valid, rd, wr, is_load.
- On every rising clk with rst=1:
  - M <= E and W <= M.
  - If effective stall=1 or jb=1, E <= bubble (valid=0). Otherwise E <= {1, D_rd, D_reg_write, D_is_load}.
- rst=0 (async, mid-operation included): all slot valid bits = 0. Outputs then evaluate combinationally to stall=0, pc_hold=0, flush_d=0, flush_e=0, fwd sels=0.
- match(S, r) = S.valid & S.wr & (S.rd==r) & (r!=0). Applied per source only when that source's D_rsX_used=1.
- Raw stall request = match(E, rs) for any used rs, OR (match(M, rs) & M.is_load). E-stage results are never forwarded to decode.
- Forwarding for each rs (hazard-free case):
  - If match(M, rs) & !M.is_load → sel 1.
  - Else if match(W, rs) → sel 2.
  - Else → sel 0.
  - M has priority over W (younger result wins).
- Load-use timing:
  - Load in E with a dependent instruction in D → stall 2 cycles. Cycle 1: the E match. Cycle 2: M match with is_load.
  - The dependent instruction then proceeds with sel 2.
- Non-load producer in E with a dependent instruction in D → stall 1 cycle, then sel 1.
- jb handling:
  - flush_d = jb and flush_e = jb, in the same cycle, combinational.
  - jb has priority: effective stall = raw & !jb, and pc_hold = effective stall. The PC must load the target while the wrong-path decode instruction is squashed.
- All outputs are combinational from the slots plus current inputs. Latency: 0 cycles from inputs to outputs; slot update takes 1 cycle.
- rd=0 never causes a stall or a forward.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds two output ports:
  - stall_cnt (32 bits): increments every cycle effective stall=1.
  - flush_cnt (32 bits): increments every cycle jb=1.
  - Both saturate at 32'hFFFF_FFFF and clear to 0 on rst=0.
- When undefined: no ports, no counter logic. Core behaviour is identical either way.

Test Plan:
- Reset: drive rst=0 while the slots hold a valid load → outputs stall=0, flush_d=0, fwd sels=0 immediately. After release, the first dependent decode gets no stall.
- ALU RAW: add with rd=5 decoded. Next cycle D_rs1=5, used → stall=1 for exactly 1 cycle, then fwd_rs1_sel=1. One cycle later (rs in W only) → sel=2.
- Load-use: load rd=7. Next cycle D_rs2=7 → stall=1 for 2 cycles, pc_hold mirrors stall. Third cycle stall=0 and fwd_rs2_sel=2.
- x0 and unused sources: producer rd=0 with D_rs1=0 → no stall, sel=0. Producer rd=3 with D_rs1=3 but D_rs1_used=0 → no stall, sel=0.
- Branch during stall: load-use stall active and jb=1 the same cycle → stall=0, pc_hold=0, flush_d=1, flush_e=1. Next cycle slot E is a bubble, so a reader of the load's rd that is now in D sees the load in M and gets a 1-cycle stall.
- With HAZ_PERF_CNT_EN: 3 load-use sequences and 2 jb pulses → stall_cnt=6, flush_cnt=2. Then assert rst=0 → both counters read 0.
